// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits N toggles evenly spread over a window of PRESCALER+1 clk cycles.
// Latency: command accepted on a cmd_valid&&cmd_ready edge, window starts next cycle; pulse lags its toggle decision by one edge.
// Backpressure: cmd_ready only in IDLE or on the last window cycle; commands offered at other times are dropped.
// Optional feature: define PULSE_GEN_CONT_EN for continuous mode (windows repeat with the last command until reset).
module pulse_train_gen #(
    parameter int unsigned PRESCALER = 60000,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cmd_edges,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             pulse,
    output logic             window_done,
    output logic             busy,
    output logic [CNT_W-1:0] edges_sent
);

    // Window counter spans 0..PRESCALER; accumulator must hold up to PRESCALER + 2^CNT_W.
    localparam int unsigned WIN_W = (PRESCALER < 1) ? 1 : $clog2(PRESCALER + 1);
    localparam int unsigned ACC_W = $clog2(PRESCALER + (2 ** CNT_W) + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PRESCALER);
    localparam logic [ACC_W-1:0] WIN_LEN  = ACC_W'(PRESCALER + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIN_W-1:0]   win_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   n_eff;
    logic [CNT_W-1:0]   n_clamp;
    logic               win_end;
    logic               toggle;
    logic               accept;

    // Last cycle of the active window; also the only in-window cycle a new command can land.
    assign win_end     = (state_q == RUN) && (win_cnt == WIN_LAST);
    assign window_done = win_end;
    assign busy        = (state_q == RUN);

    // Bresenham-style spreading: toggle whenever the running sum wraps past the window length.
    assign sum    = acc + ACC_W'(n_eff);
    assign toggle = (state_q == RUN) && (sum >= WIN_LEN);

    // Clamp requested edge count to the number of cycles able to carry a toggle.
    always_comb begin
        n_clamp = cmd_edges;
        if (32'(cmd_edges) > PRESCALER) begin
            n_clamp = CNT_W'(PRESCALER);
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (win_end) begin
                    cmd_ready = 1'b1;
`ifdef PULSE_GEN_CONT_EN
                    state_d = RUN;
`else
                    if (!cmd_valid) begin
                        state_d = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        accept = cmd_valid && cmd_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window datapath: accept loads a fresh window, otherwise advance counters while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse      <= 1'b0;
            edges_sent <= '0;
            acc        <= '0;
            win_cnt    <= '0;
            n_eff      <= '0;
        end else begin
            // Pulse level carries over between windows; the last toggle of a window lands on its final edge.
            if (toggle) begin
                pulse <= ~pulse;
            end
            if (accept) begin
                n_eff      <= n_clamp;
                win_cnt    <= '0;
                acc        <= '0;
                edges_sent <= '0;
`ifdef PULSE_GEN_CONT_EN
            end else if (win_end) begin
                // No new command: rerun the window with the previous edge count.
                win_cnt    <= '0;
                acc        <= '0;
                edges_sent <= '0;
`endif
            end else if (state_q == RUN) begin
                acc     <= toggle ? (sum - WIN_LEN) : sum;
                win_cnt <= win_end ? '0 : (win_cnt + WIN_W'(1));
                if (toggle) begin
                    edges_sent <= edges_sent + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen with PRESCALER=9, CNT_W=7.
// Reference: toggle in window cycle k iff floor((k+1)*N/(P+1)) > floor(k*N/(P+1)).
// Works with or without PULSE_GEN_CONT_EN defined.
module tb_pulse_train_gen;

    localparam int P     = 9;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] cmd_edges;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             pulse;
    logic             window_done;
    logic             busy;
    logic [CNT_W-1:0] edges_sent;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_pulse;
    int last_cnt;

    pulse_train_gen #(.PRESCALER(P), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_edges  (cmd_edges),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .pulse      (pulse),
        .window_done(window_done),
        .busy       (busy),
        .edges_sent (edges_sent)
    );

    always #5 clk = ~clk;

    function automatic bit tog(input int k, input int n);
        return (((k + 1) * n) / (P + 1)) != ((k * n) / (P + 1));
    endfunction

    function automatic int clampn(input int n);
        return (n > P) ? P : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_edges = '0;
        step();
        step();
        reset     = 1'b0;
        exp_pulse = 1'b0;
        last_cnt  = 0;
        step();
    endtask

    task automatic accept(input int n_raw);
        cmd_valid = 1'b1;
        cmd_edges = CNT_W'(n_raw);
        step();
        cmd_valid = 1'b0;
    endtask

    // Walk one window from cycle 0 to P; optionally offer the next command on the last cycle.
    task automatic run_window(input int n_raw, input bit chain, input int next_raw, input bit noise);
        int n;
        int cnt;
        n   = clampn(n_raw);
        cnt = 0;
        for (int k = 0; k <= P; k++) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL win_busy n=%0d k=%0d got=%b exp=1", n, k, busy);
            end
            n_checks++;
            if (window_done !== (k == P)) begin
                n_fail++; $display("FAIL win_done n=%0d k=%0d got=%b exp=%b", n, k, window_done, (k == P));
            end
            n_checks++;
            if (cmd_ready !== (k == P)) begin
                n_fail++; $display("FAIL win_ready n=%0d k=%0d got=%b exp=%b", n, k, cmd_ready, (k == P));
            end
            n_checks++;
            if (pulse !== exp_pulse) begin
                n_fail++; $display("FAIL win_pulse n=%0d k=%0d got=%b exp=%b", n, k, pulse, exp_pulse);
            end
            n_checks++;
            if (edges_sent !== CNT_W'(cnt)) begin
                n_fail++; $display("FAIL win_edges n=%0d k=%0d got=%0d exp=%0d", n, k, edges_sent, cnt);
            end
            if (k == P) begin
                cmd_valid = chain;
                cmd_edges = CNT_W'(next_raw);
            end else if (noise) begin
                cmd_valid = 1'($urandom % 2);
                cmd_edges = CNT_W'($urandom);
            end
            step();
            cmd_valid = 1'b0;
            if (tog(k, n)) begin
                exp_pulse = ~exp_pulse;
                cnt++;
            end
        end
        last_cnt = cnt;
    endtask

    task automatic check_idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            n_checks++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1 || window_done !== 1'b0) begin
                n_fail++; $display("FAIL idle_ctrl c=%0d busy=%b ready=%b done=%b exp=0/1/0", c, busy, cmd_ready, window_done);
            end
            n_checks++;
            if (edges_sent !== CNT_W'(last_cnt)) begin
                n_fail++; $display("FAIL idle_edges c=%0d got=%0d exp=%0d", c, edges_sent, last_cnt);
            end
            n_checks++;
            if (pulse !== exp_pulse) begin
                n_fail++; $display("FAIL idle_pulse c=%0d got=%b exp=%b", c, pulse, exp_pulse);
            end
            step();
        end
    endtask

    // After a window with no follow-up command: idle in default mode, automatic rerun in continuous mode.
    task automatic finish_window(input int n_raw);
`ifdef PULSE_GEN_CONT_EN
        run_window(n_raw, 1'b0, 0, 1'b0);
`else
        check_idle(2);
`endif
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_edges = CNT_W'(5);
        step();
        step();
        step();
        n_checks++;
        if (pulse !== 1'b0 || busy !== 1'b0 || window_done !== 1'b0 || edges_sent !== '0) begin
            n_fail++; $display("FAIL reset_outputs pulse=%b busy=%b done=%b edges=%0d exp=0/0/0/0", pulse, busy, window_done, edges_sent);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        step();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release ready=%b busy=%b exp=1/0", cmd_ready, busy);
        end
        exp_pulse = 1'b0;
        last_cnt  = 0;
    endtask

    task automatic test_basic();
        apply_reset();
        accept(4);
        run_window(4, 1'b0, 0, 1'b0);
        finish_window(4);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        accept(4);
        run_window(4, 1'b1, 2, 1'b0);
        run_window(2, 1'b0, 0, 1'b0);
        finish_window(2);
    endtask

    task automatic test_clamp();
        apply_reset();
        accept(100);
        run_window(100, 1'b0, 0, 1'b0);
        finish_window(100);
    endtask

    task automatic test_zero();
        apply_reset();
        accept(0);
        run_window(0, 1'b0, 0, 1'b1);
        finish_window(0);
    endtask

    task automatic test_reset_mid();
        int nv[2] = '{4, 7};
        foreach (nv[i]) begin
            apply_reset();
            accept(nv[i]);
            for (int k = 0; k < 5; k++) begin
                step();
            end
            reset = 1'b1;
            step();
            reset = 1'b0;
            n_checks++;
            if (pulse !== 1'b0 || busy !== 1'b0 || edges_sent !== '0 || cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_mid n=%0d pulse=%b busy=%b edges=%0d ready=%b exp=0/0/0/1", nv[i], pulse, busy, edges_sent, cmd_ready);
            end
        end
        exp_pulse = 1'b0;
        last_cnt  = 0;
    endtask

    task automatic test_continuous();
        apply_reset();
        accept(3);
        run_window(3, 1'b0, 0, 1'b0);
`ifdef PULSE_GEN_CONT_EN
        run_window(3, 1'b0, 0, 1'b0);
        run_window(3, 1'b0, 0, 1'b0);
`else
        check_idle(5);
`endif
    endtask

    task automatic test_random();
        int n;
        int nn;
        bit chain;
        apply_reset();
        n = int'($urandom_range(0, 127));
        accept(n);
        for (int i = 0; i < 12; i++) begin
            chain = 1'($urandom % 2);
            nn    = int'($urandom_range(0, 127));
            if (($urandom % 3) == 0) begin
                nn = int'($urandom_range(0, P));
            end
            run_window(n, chain, nn, 1'b1);
            if (chain) begin
                n = nn;
            end else begin
`ifndef PULSE_GEN_CONT_EN
                check_idle(int'($urandom_range(1, 3)));
                accept(nn);
                n = nn;
`endif
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_edges = '0;
        exp_pulse = 1'b0;
        last_cnt  = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_clamp();
        test_zero();
        test_reset_mid();
        test_continuous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL have parameter PRESCALER, default 60000, meaning the gate window is PRESCALER+1 clk cycles (window cycle index 0..PRESCALER).
REQ-002 The block SHALL have parameter CNT_W, default 7, meaning the width of the edge-count command and status.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd_edges, input, CNT_W bits: the number of pulse edges (toggles) to emit in one window.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: cmd_edges is valid.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted this cycle if cmd_valid=1.
REQ-008 The block SHALL have port pulse, output, 1 bit: the generated pulse train, registered.
REQ-009 The block SHALL have port window_done, output, 1 bit: a one-cycle strobe on the last window cycle (index PRESCALER).
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port edges_sent, output, CNT_W bits: toggles emitted so far in the current window.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and RUN; reset enters IDLE.
REQ-013 cmd_ready SHALL be 1 in IDLE and in RUN when win_cnt==PRESCALER; otherwise 0.
REQ-014 Accept SHALL occur when cmd_valid&&cmd_ready: N_eff = min(cmd_edges, PRESCALER) is latched, win_cnt=0, acc=0, edges_sent=0, and RUN is entered at the next edge.
REQ-015 In RUN, each cycle: sum = acc + N_eff; if sum >= PRESCALER+1 then acc <= sum-(PRESCALER+1) and pulse toggles; else acc <= sum.
REQ-016 pulse SHALL change on the clock edge that ends the window cycle in which the toggle condition holds (latency 1).
REQ-017 Exactly N_eff toggles SHALL occur per window; with N_eff>0, the last one SHALL occur in window cycle PRESCALER, and acc SHALL end at 0.
REQ-018 The acc width SHALL hold PRESCALER+2^CNT_W without overflow; win_cnt SHALL be wide enough for PRESCALER.
REQ-019 edges_sent SHALL increment on each toggle and SHALL saturate-free count to N_eff.
REQ-020 edges_sent SHALL hold its final value after the window until the next accept clears it.
REQ-021 pulse SHALL NOT be reinitialised between windows; its level carries over.
REQ-022 On window end (win_cnt==PRESCALER): accept if offered, giving back-to-back windows with no gap; otherwise follow REQ-033.
REQ-023 cmd_edges=0 SHALL run a full window with no toggles; window_done SHALL still pulse.
REQ-024 cmd_valid while cmd_ready=0 SHALL be ignored; cmd_valid need not be held.

Reset
REQ-025 Reset SHALL take priority over all other inputs, including mid-window.
REQ-026 Reset SHALL set state=IDLE, pulse=0, window_done=0, busy=0, edges_sent=0, acc=0, win_cnt=0, and latched N_eff=0.
REQ-027 Reset SHALL set cmd_ready=1 from the first cycle after reset deasserts.
REQ-028 A command presented during reset SHALL NOT be accepted.

Configuration
REQ-029 Macro PULSE_GEN_CONT_EN SHALL select continuous mode.
REQ-030 With PULSE_GEN_CONT_EN defined and no command at window end, the block SHALL restart a window with the previous N_eff, clearing edges_sent.
REQ-031 With PULSE_GEN_CONT_EN defined, busy SHALL stay 1 after the first accept until reset.
REQ-032 With PULSE_GEN_CONT_EN defined, IDLE SHALL be reached only via reset.
REQ-033 Without PULSE_GEN_CONT_EN, the block SHALL return to IDLE after window end when no command is accepted; busy SHALL then be 0.

Verification
REQ-034 PRESCALER=9, accept N=4 -> toggles in window cycles 2,4,7,9; pulse 0->1->0->1->0; edges_sent=4; window_done at cycle 9.
REQ-035 PRESCALER=9, N=4 then N=2 offered at cycle 9 -> second window starts next cycle, toggles at cycles 4,9, no idle gap.
REQ-036 PRESCALER=9, N=100 -> clamped to 9; 9 toggles, none in cycle 0; edges_sent=9.
REQ-037 N=0 -> pulse constant, edges_sent=0, window_done once, busy 1 for 10 cycles.
REQ-038 Reset asserted at window cycle 5 of N=4 -> next cycle pulse=0, busy=0, edges_sent=0, cmd_ready=1.
REQ-039 PULSE_GEN_CONT_EN defined, single N=3 command, no further cmd_valid -> repeated 3-toggle windows, window_done every 10 cycles; without the macro -> IDLE after first window.
